hazard_scoreboard: RTL and testbench



---
 rtl/hazard_pkg.sv | 24 ++
 rtl/scb_entry.sv | 47 ++++
 rtl/hazard_scoreboard.sv | 138 +++++++++++++
 tb/tb_hazard_scoreboard.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and default geometry for the decode hazard scoreboard.
package hazard_pkg;

  localparam int unsigned DefNsrc  = 6;
  localparam int unsigned DefNdst  = 5;
  localparam int unsigned DefRegAw = 6;
  localparam int unsigned DefLatW  = 3;
  localparam int unsigned LaneW    = $clog2(DefNdst);
  localparam int unsigned FwdW     = $clog2(DefNdst + 1);

  typedef logic [DefRegAw-1:0] reg_addr_t;
  typedef logic [DefLatW-1:0]  lat_t;
  typedef logic [LaneW-1:0]    lane_t;
  typedef logic [FwdW-1:0]     fwd_sel_t;

  typedef struct packed {
    logic  busy;
    lat_t  cnt;
    lane_t lane;
  } scb_entry_t;

  localparam fwd_sel_t FWD_REGFILE = '0;

endpackage

// File: rtl/scb_entry.sv
// One scoreboard entry: countdown, retire, issue override and flush kill for a single register.
module scb_entry
  import hazard_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  input  logic       hold,
  input  logic       flush,
  input  logic       issue_we,
  input  lat_t       issue_cnt,
  input  lane_t      issue_lane,
  output scb_entry_t entry
);

  scb_entry_t entry_q, entry_d;

  always_comb begin
    entry_d = entry_q;
    if (flush && entry_q.busy && (entry_q.cnt > lat_t'(1))) begin
      entry_d = '0;
    end else if (flush || !hold) begin
      // Issue wins over this cycle's own decrement or retire.
      if (issue_we) begin
        entry_d.busy = 1'b1;
        entry_d.cnt  = issue_cnt;
        entry_d.lane = issue_lane;
      end else if (entry_q.busy) begin
        if (entry_q.cnt != '0) begin
          entry_d.cnt = entry_q.cnt - lat_t'(1);
        end else begin
          entry_d = '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      entry_q <= '0;
    end else begin
      entry_q <= entry_d;
    end
  end

  assign entry = entry_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Latency-aware register scoreboard producing decode stall and bypass-lane selects.
// Optional stall statistics counters are built when HAZARD_STATS_EN is defined.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int unsigned NSRC   = DefNsrc,
  parameter int unsigned NDST   = DefNdst,
  parameter int unsigned REG_AW = DefRegAw,
  parameter int unsigned LAT_W  = DefLatW
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic [NSRC*REG_AW-1:0]            rs,
  input  logic [NSRC-1:0]                   rs_mask,
  input  logic                              issue_valid,
  input  logic [NDST*REG_AW-1:0]            issue_rd,
  input  logic [NDST-1:0]                   issue_rd_mask,
  input  logic [LAT_W-1:0]                  issue_lat,
  input  logic                              pipe_hold,
  input  logic                              flush,
  output logic                              stall,
  output logic [NSRC*$clog2(NDST+1)-1:0]    fwd_sel,
  output logic [2**REG_AW-1:0]              busy_vec
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]                       raw_stall_cnt,
  output logic [31:0]                       waw_stall_cnt
`endif
);

  localparam int unsigned NReg = 2**REG_AW;
  localparam int unsigned SelW = $clog2(NDST + 1);

  scb_entry_t       entry [NReg];
  reg_addr_t        src_addr [NSRC];
  reg_addr_t        dst_addr [NDST];
  logic [NReg-1:1]  issue_we;
  lane_t            issue_lane [NReg];
  lat_t             lat_eff, issue_cnt;
  logic             raw, waw, issue_fire;

  // A zero latency is illegal; treat it as one so the table stays consistent.
  assign lat_eff   = (issue_lat == '0) ? lat_t'(1) : issue_lat;
  assign issue_cnt = lat_eff - lat_t'(1);

  always_comb begin
    for (int s = 0; s < NSRC; s++) src_addr[s] = rs[s*REG_AW +: REG_AW];
    for (int d = 0; d < NDST; d++) dst_addr[d] = issue_rd[d*REG_AW +: REG_AW];
  end

  always_comb begin
    raw     = 1'b0;
    fwd_sel = '0;
    for (int s = 0; s < NSRC; s++) begin
      fwd_sel[s*SelW +: SelW] = FWD_REGFILE;
      if (rs_mask[s] && (src_addr[s] != '0) && entry[src_addr[s]].busy) begin
        if (entry[src_addr[s]].cnt == '0) begin
          fwd_sel[s*SelW +: SelW] = fwd_sel_t'(entry[src_addr[s]].lane) + fwd_sel_t'(1);
        end else begin
          raw = 1'b1;
        end
      end
    end
  end

  // Older write must complete strictly before the new one to keep results in order.
  always_comb begin
    waw = 1'b0;
    for (int d = 0; d < NDST; d++) begin
      if (issue_rd_mask[d] && (dst_addr[d] != '0) && entry[dst_addr[d]].busy &&
          (entry[dst_addr[d]].cnt >= lat_eff)) begin
        waw = 1'b1;
      end
    end
  end

  assign stall      = issue_valid & (raw | waw);
  assign issue_fire = issue_valid & ~stall & ~pipe_hold & ~flush;

  // Ascending lane scan so the highest lane wins on duplicate destinations.
  always_comb begin
    issue_we      = '0;
    issue_lane[0] = '0;
    for (int r = 1; r < NReg; r++) begin
      issue_lane[r] = '0;
      for (int d = 0; d < NDST; d++) begin
        if (issue_fire && issue_rd_mask[d] && (dst_addr[d] == reg_addr_t'(r))) begin
          issue_we[r]   = 1'b1;
          issue_lane[r] = lane_t'(d);
        end
      end
    end
  end

  assign entry[0] = '0;

  for (genvar r = 1; r < NReg; r++) begin : g_entry
    scb_entry u_entry (
      .clk       (clk),
      .rstn      (rstn),
      .hold      (pipe_hold),
      .flush     (flush),
      .issue_we  (issue_we[r]),
      .issue_cnt (issue_cnt),
      .issue_lane(issue_lane[r]),
      .entry     (entry[r])
    );
  end

  always_comb begin
    for (int r = 0; r < NReg; r++) busy_vec[r] = entry[r].busy;
  end

`ifdef HAZARD_STATS_EN
  logic [31:0] raw_stall_q, waw_stall_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      raw_stall_q <= '0;
      waw_stall_q <= '0;
    end else if (issue_valid && !pipe_hold) begin
      if (raw) begin
        if (raw_stall_q != '1) raw_stall_q <= raw_stall_q + 32'd1;
      end else if (waw) begin
        if (waw_stall_q != '1) waw_stall_q <= waw_stall_q + 32'd1;
      end
    end
  end

  assign raw_stall_cnt = raw_stall_q;
  assign waw_stall_cnt = waw_stall_q;
`endif

  issue_lat_nonzero : assert property (@(posedge clk) disable iff (!rstn)
    issue_valid |-> (issue_lat != '0))
    else $error("issue_lat of zero with issue_valid");

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed plus random bench for hazard_scoreboard against a per-register table model.
module tb_hazard_scoreboard;

  localparam int NSRC = 6;
  localparam int NDST = 5;
  localparam int AW   = 6;
  localparam int LW   = 3;
  localparam int NREG = 64;
  localparam int FW   = 3;

  logic                 clk = 1'b0;
  logic                 rstn;
  logic [NSRC*AW-1:0]   rs;
  logic [NSRC-1:0]      rs_mask;
  logic                 issue_valid;
  logic [NDST*AW-1:0]   issue_rd;
  logic [NDST-1:0]      issue_rd_mask;
  logic [LW-1:0]        issue_lat;
  logic                 pipe_hold;
  logic                 flush;
  logic                 stall;
  logic [NSRC*FW-1:0]   fwd_sel;
  logic [NREG-1:0]      busy_vec;
`ifdef HAZARD_STATS_EN
  logic [31:0]          raw_stall_cnt, waw_stall_cnt;
`endif

  always #5 clk = ~clk;

  hazard_scoreboard u_dut (
    .clk          (clk),
    .rstn         (rstn),
    .rs           (rs),
    .rs_mask      (rs_mask),
    .issue_valid  (issue_valid),
    .issue_rd     (issue_rd),
    .issue_rd_mask(issue_rd_mask),
    .issue_lat    (issue_lat),
    .pipe_hold    (pipe_hold),
    .flush        (flush),
    .stall        (stall),
    .fwd_sel      (fwd_sel),
    .busy_vec     (busy_vec)
`ifdef HAZARD_STATS_EN
    ,
    .raw_stall_cnt(raw_stall_cnt),
    .waw_stall_cnt(waw_stall_cnt)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference table: what each register is waiting for, in plain integers.
  bit m_busy [NREG];
  int m_cnt  [NREG];
  int m_lane [NREG];
  int m_raw_n, m_waw_n;

  logic              last_stall;
  logic [NSRC*FW-1:0] last_fwd;
  logic [NREG-1:0]   last_busy;

  task automatic cycle();
    bit raw, waw, exp_stall, fire;
    logic [NSRC*FW-1:0] exp_fwd;
    logic [FW-1:0]      sel;
    logic [63:0]        exp_busy;
    int lat, a;
    bit n_busy [NREG];
    int n_cnt  [NREG];
    int n_lane [NREG];
    @(negedge clk);
    lat = (issue_lat == 0) ? 1 : int'(issue_lat);
    raw = 0;
    waw = 0;
    exp_fwd = '0;
    for (int s = 0; s < NSRC; s++) begin
      a = int'(rs[s*AW +: AW]);
      if (rs_mask[s] && a != 0 && m_busy[a]) begin
        if (m_cnt[a] == 0) begin
          sel = FW'(m_lane[a] + 1);
          exp_fwd[s*FW +: FW] = sel;
        end else begin
          raw = 1;
        end
      end
    end
    for (int d = 0; d < NDST; d++) begin
      a = int'(issue_rd[d*AW +: AW]);
      if (issue_rd_mask[d] && a != 0 && m_busy[a] && m_cnt[a] >= lat) waw = 1;
    end
    exp_stall = issue_valid && (raw || waw);
    for (int r = 0; r < NREG; r++) exp_busy[r] = m_busy[r];

    last_stall = stall;
    last_fwd   = fwd_sel;
    last_busy  = busy_vec;
    check("stall", 64'(stall), 64'(exp_stall));
    check("fwd_sel", 64'(fwd_sel), 64'(exp_fwd));
    check("busy_vec", busy_vec, exp_busy);
`ifdef HAZARD_STATS_EN
    check("raw_stall_cnt", 64'(raw_stall_cnt), 64'(m_raw_n));
    check("waw_stall_cnt", 64'(waw_stall_cnt), 64'(m_waw_n));
`endif

    fire = issue_valid && !exp_stall && !pipe_hold && !flush;
    for (int r = 0; r < NREG; r++) begin
      n_busy[r] = m_busy[r];
      n_cnt[r]  = m_cnt[r];
      n_lane[r] = m_lane[r];
      if (!rstn || (flush && m_busy[r] && m_cnt[r] > 1)) begin
        n_busy[r] = 0;
        n_cnt[r]  = 0;
        n_lane[r] = 0;
      end else if ((flush || !pipe_hold) && m_busy[r]) begin
        if (m_cnt[r] > 0) n_cnt[r] = m_cnt[r] - 1;
        else n_busy[r] = 0;
      end
    end
    if (rstn && fire) begin
      for (int d = 0; d < NDST; d++) begin
        a = int'(issue_rd[d*AW +: AW]);
        if (issue_rd_mask[d] && a != 0) begin
          n_busy[a] = 1;
          n_cnt[a]  = lat - 1;
          n_lane[a] = d;
        end
      end
    end
    if (!rstn) begin
      m_raw_n = 0;
      m_waw_n = 0;
    end else if (issue_valid && !pipe_hold) begin
      if (raw) m_raw_n++;
      else if (waw) m_waw_n++;
    end

    @(posedge clk);
    for (int r = 0; r < NREG; r++) begin
      m_busy[r] = n_busy[r];
      m_cnt[r]  = n_cnt[r];
      m_lane[r] = n_lane[r];
    end
    #1;
  endtask

  task automatic idle_inputs();
    rs = '0; rs_mask = '0; issue_valid = 0; issue_rd = '0; issue_rd_mask = '0;
    issue_lat = 3'd1; pipe_hold = 0; flush = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rstn = 0;
    cycle();
    rstn = 1;
  endtask

  initial begin
    for (int r = 0; r < NREG; r++) begin
      m_busy[r] = 0; m_cnt[r] = 0; m_lane[r] = 0;
    end
    m_raw_n = 0;
    m_waw_n = 0;
    idle_inputs();
    rstn = 0;
    // Reset values of the model are only meaningful once a reset edge has passed.
    @(posedge clk);
    #1;
    do_reset();
    cycle();
    check("reset_busy", last_busy, 64'd0);
    check("reset_stall", 64'(last_stall), 64'd0);

    // RAW: reg 5, latency 3.
    issue_valid = 1; issue_rd = {24'd0, 6'd5}; issue_rd_mask = 5'b00001; issue_lat = 3'd3;
    cycle();
    issue_rd_mask = '0; rs = {30'd0, 6'd5}; rs_mask = 6'b000001;
    cycle(); check("raw_stall1", 64'(last_stall), 64'd1);
    cycle(); check("raw_stall2", 64'(last_stall), 64'd1);
    cycle(); check("raw_fwd", 64'(last_fwd[FW-1:0]), 64'd1);
             check("raw_fwd_stall", 64'(last_stall), 64'd0);
    cycle(); check("raw_regfile", 64'(last_fwd[FW-1:0]), 64'd0);
             check("raw_retired", 64'(last_busy[5]), 64'd0);

    // WAW: reg 7 at cnt 4, reissue with latency 2 on lane 1.
    do_reset();
    issue_valid = 1; issue_rd = {24'd0, 6'd7}; issue_rd_mask = 5'b00001; issue_lat = 3'd5;
    cycle();
    issue_rd = {18'd0, 6'd7, 6'd0}; issue_rd_mask = 5'b00010; issue_lat = 3'd2;
    cycle(); check("waw_stall1", 64'(last_stall), 64'd1);
    cycle(); check("waw_stall2", 64'(last_stall), 64'd1);
    cycle(); check("waw_stall3", 64'(last_stall), 64'd1);
    cycle(); check("waw_accept", 64'(last_stall), 64'd0);
    issue_rd_mask = '0; rs = {30'd0, 6'd7}; rs_mask = 6'b000001;
    cycle(); check("waw_cnt1", 64'(last_stall), 64'd1);
    cycle(); check("waw_lane", 64'(last_fwd[FW-1:0]), 64'd2);

    // Vector issue on lanes 1..4, read next cycle through the bypass.
    do_reset();
    issue_valid = 1; issue_rd = {6'd15, 6'd14, 6'd13, 6'd12, 6'd0};
    issue_rd_mask = 5'b11110; issue_lat = 3'd1;
    cycle();
    issue_rd_mask = '0;
    rs = {6'd15, 6'd14, 6'd13, 6'd12, 6'd0, 6'd0}; rs_mask = 6'b111101;
    cycle();
    check("vec_fwd", 64'(last_fwd), 64'({3'd5, 3'd4, 3'd3, 3'd2, 3'd0, 3'd0}));
    check("vec_stall", 64'(last_stall), 64'd0);

    // Hold freezes reg 9 at cnt 2.
    do_reset();
    issue_valid = 1; issue_rd = {24'd0, 6'd9}; issue_rd_mask = 5'b00001; issue_lat = 3'd3;
    cycle();
    issue_rd_mask = '0; rs = {30'd0, 6'd9}; rs_mask = 6'b000001; pipe_hold = 1;
    for (int i = 0; i < 3; i++) begin
      cycle(); check("hold_stall", 64'(last_stall), 64'd1);
    end
    pipe_hold = 0;
    cycle(); cycle();
    cycle(); check("hold_release_fwd", 64'(last_fwd[FW-1:0]), 64'd1);

    // Flush kills reg 4 (cnt 5) but lets reg 3 (cnt 1) retire.
    do_reset();
    issue_valid = 1; issue_rd = {24'd0, 6'd4}; issue_rd_mask = 5'b00001; issue_lat = 3'd7;
    cycle();
    issue_rd = {24'd0, 6'd3}; issue_lat = 3'd2;
    cycle();
    issue_rd = {24'd0, 6'd20}; issue_lat = 3'd1; flush = 1;
    cycle();
    flush = 0; issue_valid = 0; issue_rd_mask = '0;
    cycle();
    check("flush_kill", 64'(last_busy[4]), 64'd0);
    check("flush_keep", 64'(last_busy[3]), 64'd1);
    check("flush_no_issue", 64'(last_busy[20]), 64'd0);
    cycle(); check("flush_retire", 64'(last_busy[3]), 64'd0);

    // Random traffic over a small register pool so hazards are frequent.
    for (int i = 0; i < 3000; i++) begin
      rstn        = ($urandom_range(99) != 0);
      issue_valid = ($urandom_range(9) < 7);
      for (int d = 0; d < NDST; d++) issue_rd[d*AW +: AW] = 6'($urandom_range(7));
      for (int s = 0; s < NSRC; s++) rs[s*AW +: AW] = 6'($urandom_range(7));
      issue_rd_mask = 5'($urandom);
      rs_mask       = 6'($urandom);
      issue_lat     = 3'($urandom_range(7, 1));
      pipe_hold     = ($urandom_range(7) == 0);
      flush         = ($urandom_range(15) == 0);
      cycle();
    end

    // Mid-operation reset.
    rstn = 1;
    pipe_hold = 0; flush = 0; issue_valid = 1;
    issue_rd = {6'd1, 6'd2, 6'd3, 6'd4, 6'd5}; issue_rd_mask = 5'b11111; issue_lat = 3'd7;
    cycle();
    rstn = 0;
    cycle();
    rstn = 1;
    idle_inputs();
    cycle();
    check("midrun_reset", last_busy, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
